// File: rtl/booth_ctrl_if.sv
// Control/status bundle between the Booth multiplier controller and its datapath.
// The controller takes the master modport; the datapath (and start requester) the slave.
interface booth_ctrl_if;
    logic start;
    logic q0;
    logic qm1;
    logic eqz;
    logic ldA;
    logic clrA;
    logic sftA;
    logic ldQ;
    logic clrQ;
    logic sftQ;
    logic clrff;
    logic ldM;
    logic addsub;
    logic ldcnt;
    logic decr;
    logic busy;
    logic done;

    modport master (
        input  start, q0, qm1, eqz,
        output ldA, clrA, sftA, ldQ, clrQ, sftQ, clrff, ldM,
               addsub, ldcnt, decr, busy, done
    );

    modport slave (
        output start, q0, qm1, eqz,
        input  ldA, clrA, sftA, ldQ, clrQ, sftQ, clrff, ldM,
               addsub, ldcnt, decr, busy, done
    );
endinterface

// File: rtl/booth_ctrl.sv
// Moore control FSM for a radix-2 Booth multiplier: loads M and Q, then runs
// WIDTH evaluate/add-sub/shift iterations and pulses done with {A,Q} valid.
module booth_ctrl #(
    parameter int WIDTH = 16
) (
    input logic        clk,
    input logic        rst,
    booth_ctrl_if.master bus
);

    // WIDTH sets the datapath counter preload; the FSM itself relies on eqz.
    if (WIDTH < 1) begin : g_width_check
        $error("booth_ctrl: WIDTH must be at least 1");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_M = 3'd1,
        S_LOAD_Q = 3'd2,
        S_EVAL   = 3'd3,
        S_ADD    = 3'd4,
        S_SUB    = 3'd5,
        S_SHIFT  = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    state_t state;
    state_t state_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE:   state_nxt = bus.start ? S_LOAD_M : S_IDLE;
            S_LOAD_M: state_nxt = S_LOAD_Q;
            S_LOAD_Q: state_nxt = S_EVAL;
            S_EVAL: begin
                // Counter exhaustion wins over the Booth pair.
                if (bus.eqz) begin
                    state_nxt = S_DONE;
                end else begin
                    case ({bus.q0, bus.qm1})
                        2'b10:   state_nxt = S_SUB;
                        2'b01:   state_nxt = S_ADD;
                        default: state_nxt = S_SHIFT;
                    endcase
                end
            end
            S_ADD:    state_nxt = S_SHIFT;
            S_SUB:    state_nxt = S_SHIFT;
            S_SHIFT:  state_nxt = S_EVAL;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        bus.ldA    = 1'b0;
        bus.clrA   = 1'b0;
        bus.sftA   = 1'b0;
        bus.ldQ    = 1'b0;
        bus.clrQ   = 1'b0;
        bus.sftQ   = 1'b0;
        bus.clrff  = 1'b0;
        bus.ldM    = 1'b0;
        bus.addsub = 1'b0;
        bus.ldcnt  = 1'b0;
        bus.decr   = 1'b0;
        bus.busy   = (state != S_IDLE);
        bus.done   = 1'b0;
        case (state)
            S_LOAD_M: begin
                bus.ldM   = 1'b1;
                bus.clrA  = 1'b1;
                bus.clrff = 1'b1;
                bus.ldcnt = 1'b1;
            end
            S_LOAD_Q: bus.ldQ = 1'b1;
            S_ADD: begin
                bus.ldA    = 1'b1;
                bus.addsub = 1'b1;
            end
            S_SUB:    bus.ldA = 1'b1;
            S_SHIFT: begin
                bus.sftA = 1'b1;
                bus.sftQ = 1'b1;
                bus.decr = 1'b1;
            end
            S_DONE:   bus.done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_booth_ctrl.sv
// Directed bench for booth_ctrl driving a behavioural 16-bit Booth datapath.
// Checks output decode, latency, iteration mix, product, start/reset handling.
module tb_booth_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] data_in = '0;

    booth_ctrl_if bus ();

    booth_ctrl #(.WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Behavioural datapath: A, Q, Q(-1), M and iteration counter.
    logic [15:0] a_r   = '0;
    logic [15:0] q_r   = '0;
    logic [15:0] m_r   = '0;
    logic        qm1_r = 1'b0;
    logic [4:0]  cnt_r = '0;

    always @(posedge clk) begin
        if (bus.ldM) m_r <= data_in;
        if (bus.clrA) a_r <= '0;
        else if (bus.ldA) a_r <= bus.addsub ? a_r + m_r : a_r - m_r;
        else if (bus.sftA) a_r <= {a_r[15], a_r[15:1]};
        if (bus.ldQ) q_r <= data_in;
        else if (bus.sftQ) q_r <= {a_r[0], q_r[15:1]};
        if (bus.clrff) qm1_r <= 1'b0;
        else if (bus.sftQ) qm1_r <= q_r[0];
        if (bus.ldcnt) cnt_r <= 5'd16;
        else if (bus.decr) cnt_r <= cnt_r - 5'd1;
    end

    assign bus.q0  = q_r[0];
    assign bus.qm1 = qm1_r;
    assign bus.eqz = (cnt_r == 5'd0);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // {ldA,clrA,sftA,ldQ,clrQ,sftQ,clrff,ldM,addsub,ldcnt,decr,busy,done}
    function automatic logic [12:0] outs();
        return {bus.ldA, bus.clrA, bus.sftA, bus.ldQ, bus.clrQ, bus.sftQ,
                bus.clrff, bus.ldM, bus.addsub, bus.ldcnt, bus.decr, bus.busy, bus.done};
    endfunction

    localparam logic [12:0] OUT_LOAD_M = 13'b0_1_0_0_0_0_1_1_0_1_0_1_0;
    localparam logic [12:0] OUT_LOAD_Q = 13'b0_0_0_1_0_0_0_0_0_0_0_1_0;

    task automatic run_op(input string name, input logic [15:0] m, input logic [15:0] q,
                          input int exp_lat, input int exp_add, input int exp_sub,
                          input logic [31:0] exp_prod, input bit poke, input int rst_at);
        int  done_cyc   = -1;
        int  shifts     = 0;
        int  adds       = 0;
        int  subs       = 0;
        int  clrq       = 0;
        int  gaps       = 0;
        int  stray      = 0;
        int  late_busy  = 0;
        bit  poked      = 1'b0;
        bit  aborted    = 1'b0;
        @(negedge clk);
        bus.start = 1'b1;
        data_in   = m;
        @(posedge clk);
        for (int c = 1; c <= 80; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            data_in   = bus.ldQ ? q : m;
            if (c == 1) check({name, "_load_m"}, 32'(outs()), 32'(OUT_LOAD_M));
            if (c == 2) check({name, "_load_q"}, 32'(outs()), 32'(OUT_LOAD_Q));
            if (!bus.busy) gaps++;
            if (bus.sftA) shifts++;
            if (bus.ldA && bus.addsub) adds++;
            if (bus.ldA && !bus.addsub) subs++;
            if (bus.clrQ) clrq++;
            if (bus.addsub && !bus.ldA) stray++;
            if (c == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                check({name, "_rst_outs"}, 32'(outs()), 32'd0);
                rst = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (poke && bus.sftA && !poked) begin
                bus.start = 1'b1;
                poked     = 1'b1;
            end
            if (bus.done) begin
                done_cyc = c;
                if (poke) bus.start = 1'b1;
                break;
            end
        end
        if (aborted) begin
            check({name, "_no_done"}, 32'(done_cyc), 32'hFFFF_FFFF);
        end else begin
            check({name, "_latency"}, 32'(done_cyc), 32'(exp_lat));
            check({name, "_product"}, {a_r, q_r}, exp_prod);
            check({name, "_shifts"}, 32'(shifts), 32'd16);
            check({name, "_adds"}, 32'(adds), 32'(exp_add));
            check({name, "_subs"}, 32'(subs), 32'(exp_sub));
            check({name, "_clrq"}, 32'(clrq), 32'd0);
            check({name, "_busy_gaps"}, 32'(gaps), 32'd0);
            check({name, "_addsub_stray"}, 32'(stray), 32'd0);
            @(negedge clk);
            bus.start = 1'b0;
            check({name, "_after_done"}, {30'd0, bus.busy, bus.done}, 32'd0);
            if (poke) begin
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    if (bus.busy) late_busy++;
                end
                check({name, "_no_queued_start"}, 32'(late_busy), 32'd0);
            end
        end
    endtask

    initial begin
        bus.start = 1'b1;
        rst       = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", 32'(outs()), 32'd0);
        rst       = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_after_rst", 32'(outs()), 32'd0);

        // 3*5: SUB,ADD,SUB,ADD then shifts only.
        run_op("m3q5", 16'd3, 16'd5, 40, 2, 2, 32'd15, 1'b0, 0);
        // Zero multiplier: shifts only; start poked in SHIFT and in DONE.
        run_op("m7q0", 16'd7, 16'd0, 36, 0, 0, 32'd0, 1'b1, 0);
        // -3 * 0x5555 = -65535: alternating bits force ADD/SUB every iteration.
        run_op("mneg", 16'hFFFD, 16'h5555, 52, 8, 8, 32'hFFFF_0001, 1'b0, 0);
        // Abort at cycle 20, then a clean rerun.
        run_op("abort", 16'd3, 16'd5, 0, 0, 0, 32'd0, 1'b0, 20);
        run_op("rerun", 16'd3, 16'd5, 40, 2, 2, 32'd15, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
